// File: rtl/tri_pkg.sv
// Shared types and sizes for the triangle frame buffer: grid geometry,
// coordinate and row vector types, and the controller state encoding.
package tri_pkg;
  localparam int COORD_W   = 3;
  localparam int GRID_N    = 1 << COORD_W;
  localparam int PIX_CNT_W = 2 * COORD_W + 1;

  typedef logic [COORD_W-1:0]   coord_t;
  typedef logic [GRID_N-1:0]    row_t;
  typedef logic [PIX_CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CAPT  = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;
endpackage

// File: rtl/tri_frame_buffer_if.sv
// Pixel stream, control and readback signals between the rasterizer side
// (master) and the frame buffer (slave).
interface tri_frame_buffer_if;
  import tri_pkg::*;

  logic   busy_i;
  logic   po_i;
  coord_t xo_i;
  coord_t yo_i;
  logic   clr;
  logic   rd_req;
  coord_t rd_row;
  logic   rd_valid;
  row_t   rd_data;
  cnt_t   pix_cnt;
  logic   done;
  logic   ready;
  logic   ovf;

  modport master (
    output busy_i, po_i, xo_i, yo_i, clr, rd_req, rd_row,
    input  rd_valid, rd_data, pix_cnt, done, ready, ovf
  );

  modport slave (
    input  busy_i, po_i, xo_i, yo_i, clr, rd_req, rd_row,
    output rd_valid, rd_data, pix_cnt, done, ready, ovf
  );
endinterface

// File: rtl/tri_fb_bitmap.sv
// N x N pixel bitmap in registers: OR-only pixel set with a was-zero probe,
// whole-row clear, and a registered row read (read-before-write).
module tri_fb_bitmap
  import tri_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   set_en_i,
  input  coord_t set_x_i,
  input  coord_t set_y_i,
  output logic   was_zero_o,
  input  logic   clr_en_i,
  input  coord_t clr_row_i,
  input  logic   rd_en_i,
  input  coord_t rd_row_i,
  output row_t   rd_data_o
);
  row_t rows_w [GRID_N];
  row_t rd_data_q;

  generate
    for (genvar gi = 0; gi < GRID_N; gi++) begin : g_row
      row_t row_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          row_q <= '0;
        end else if (clr_en_i && (clr_row_i == coord_t'(gi))) begin
          row_q <= '0;
        end else if (set_en_i && (set_y_i == coord_t'(gi))) begin
          row_q[set_x_i] <= 1'b1;
        end
      end

      assign rows_w[gi] = row_q;
    end
  endgenerate

  // Probe the current bit so the caller counts only genuine 0->1 transitions.
  assign was_zero_o = ~rows_w[set_y_i][set_x_i];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= rows_w[rd_row_i];
    end
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/tri_frame_buffer.sv
// Frame buffer controller: captures rasterizer pixels into the bitmap,
// counts set pixels, pulses done per triangle and runs the row clear sweep.
module tri_frame_buffer
  import tri_pkg::*;
#(
  parameter int W     = COORD_W,
  parameter int CNT_W = PIX_CNT_W
) (
  input logic               clk,
  input logic               reset,
  tri_frame_buffer_if.slave bus
);
  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] CAPT  = ST_CAPT;
  localparam logic [1:0] CLEAR = ST_CLEAR;

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     clr_row_q, clr_row_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             busy_seen_q, busy_seen_d;
  logic             rd_valid_q;

  logic pix_ok;
  logic set_en;
  logic was_zero;
  logic clr_en;
  logic rd_en;
  row_t rd_data_w;

  assign pix_ok = bus.busy_i & bus.po_i;
  assign rd_en  = bus.rd_req & (state_q != CLEAR);

  always_comb begin
    state_d     = state_q;
    clr_row_d   = clr_row_q;
    pix_cnt_d   = pix_cnt_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    busy_seen_d = busy_seen_q;
    set_en      = 1'b0;
    clr_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.busy_i) begin
          state_d = CAPT;
          set_en  = pix_ok;
        end else if (bus.clr) begin
          state_d     = CLEAR;
          clr_row_d   = '0;
          pix_cnt_d   = '0;
          ovf_d       = 1'b0;
          busy_seen_d = 1'b0;
        end
      end
      CAPT: begin
        set_en = pix_ok;
        if (!bus.busy_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      CLEAR: begin
        clr_en    = 1'b1;
        clr_row_d = clr_row_q + 1'b1;
        if (pix_ok) begin
          ovf_d = 1'b1;
        end
        // A triangle that starts and ends inside the sweep still owes a done.
        if (bus.busy_i) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q) begin
          done_d      = 1'b1;
          busy_seen_d = 1'b0;
        end
        if (clr_row_q == W'(GRID_N - 1)) begin
          state_d     = bus.busy_i ? CAPT : IDLE;
          busy_seen_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (set_en && was_zero) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      clr_row_q   <= '0;
      pix_cnt_q   <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      busy_seen_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_row_q   <= clr_row_d;
      pix_cnt_q   <= pix_cnt_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      busy_seen_q <= busy_seen_d;
      rd_valid_q  <= rd_en;
    end
  end

  tri_fb_bitmap u_bitmap (
    .clk        (clk),
    .reset      (reset),
    .set_en_i   (set_en),
    .set_x_i    (bus.xo_i),
    .set_y_i    (bus.yo_i),
    .was_zero_o (was_zero),
    .clr_en_i   (clr_en),
    .clr_row_i  (clr_row_q),
    .rd_en_i    (rd_en),
    .rd_row_i   (bus.rd_row),
    .rd_data_o  (rd_data_w)
  );

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_w;
  assign bus.pix_cnt  = pix_cnt_q;
  assign bus.done     = done_q;
  assign bus.ready    = (state_q != CLEAR);
  assign bus.ovf      = ovf_q;
endmodule
